multicycle_core: RTL and testbench

RV32I-subset processor core that executes one instruction over several cycles. A sequencing state machine drives a single shared, handshaked memory port, replacing the single-cycle core's separate combinational instruction and data memories. The core exposes the same register `a0` observation output, plus `retire` and `halted` status outputs. It is the core a top level instantiates when memory has variable latency.

---
 rtl/multicycle_core.sv | 257 +++++++++++++++++++++++++
 tb/tb_multicycle_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// multicycle_core: RV32I-subset core that runs each instruction over several
// cycles (FETCH, DECODE, EXEC, MEM, WB) through one shared memory port.
// Optional build macro: RV32E_EN (16-entry register file; register indices
// with bit 4 set are illegal and halt the core from DECODE).
//
// Memory handshake: the core holds mem_req high together with stable
// mem_addr/mem_we/mem_wdata until it samples mem_ready=1 on a rising edge;
// that edge completes exactly one access. mem_ready may be high in the same
// cycle mem_req rises, which gives a zero-wait access.
module multicycle_core #(
  parameter int          ADDR_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           a0,
  output logic                  retire,
  output logic                  halted
);

`ifdef RV32E_EN
  localparam int NREGS = 16;
  localparam int RAW   = 4;
`else
  localparam int NREGS = 32;
  localparam int RAW   = 5;
`endif

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t      state, next_state;
  logic [31:0] pc, ir, a_reg, b_reg, alu_out, mdr;
  logic [31:0] rf [NREGS];

  // Instruction fields
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd_f, rs1_f, rs2_f;

  assign opcode = ir[6:0];
  assign rd_f   = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1_f  = ir[19:15];
  assign rs2_f  = ir[24:20];
  assign funct7 = ir[31:25];

  // Decoded instruction class
  logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, legal;
  logic [31:0] imm, alu_b, alu_res, ls_addr, br_target, jmp_target;
  logic        br_taken;

  // Control strobes from the sequencer to the datapath
  logic        req_c, we_c, ret_c;
  logic [31:0] addr_c, wdata_c;
  logic        ir_we, ab_we, alu_we, mdr_we, pc_we, rf_we;
  logic [31:0] alu_in, pc_next, rf_wdata;

  // Instruction decode, legality check and immediate generation
  always_comb begin
    is_r    = (opcode == 7'b0110011) &&
              ((funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b111 ||
                                         funct3 == 3'b110 || funct3 == 3'b010)) ||
               (funct7 == 7'b0100000 && funct3 == 3'b000));
    is_i    = (opcode == 7'b0010011) &&
              (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110 || funct3 == 3'b010);
    is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
    is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
    is_br   = (opcode == 7'b1100011) && (funct3 == 3'b000 || funct3 == 3'b001);
    is_jal  = (opcode == 7'b1101111);
    is_jalr = (opcode == 7'b1100111) && (funct3 == 3'b000);
    is_lui  = (opcode == 7'b0110111);
    legal   = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_jalr | is_lui;
`ifdef RV32E_EN
    // Only the register fields an instruction actually uses are checked.
    if (((is_r | is_i | is_lw | is_sw | is_br | is_jalr) & rs1_f[4]) |
        ((is_r | is_sw | is_br) & rs2_f[4]) |
        ((is_r | is_i | is_lw | is_jal | is_jalr | is_lui) & rd_f[4]))
      legal = 1'b0;
`endif
    if (is_sw)
      imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    else if (is_br)
      imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    else if (is_jal)
      imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    else if (is_lui)
      imm = {ir[31:12], 12'h000};
    else
      imm = {{20{ir[31]}}, ir[31:20]};
  end

  // ALU and address/target arithmetic, all modulo 2^32
  always_comb begin
    alu_b = is_r ? b_reg : imm;
    case (funct3)
      3'b000:  alu_res = (is_r && funct7[5]) ? (a_reg - alu_b) : (a_reg + alu_b);
      3'b111:  alu_res = a_reg & alu_b;
      3'b110:  alu_res = a_reg | alu_b;
      3'b010:  alu_res = {31'b0, ($signed(a_reg) < $signed(alu_b))};
      default: alu_res = 32'h0;
    endcase
    ls_addr    = a_reg + imm;
    br_target  = pc + imm;
    br_taken   = (funct3 == 3'b000) ? (a_reg == b_reg) : (a_reg != b_reg);
    jmp_target = is_jalr ? {ls_addr[31:1], 1'b0} : br_target;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // Sequencer: next state, memory port drive and datapath strobes
  always_comb begin
    next_state = state;
    req_c      = 1'b0;
    we_c       = 1'b0;
    ret_c      = 1'b0;
    addr_c     = 32'h0;
    wdata_c    = 32'h0;
    ir_we      = 1'b0;
    ab_we      = 1'b0;
    alu_we     = 1'b0;
    mdr_we     = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    alu_in     = alu_res;
    pc_next    = pc + 32'd4;
    rf_wdata   = alu_out;
    case (state)
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = pc;
        if (mem_ready) begin
          ir_we      = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        ab_we      = 1'b1;
        next_state = legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        if (is_r || is_i || is_lui) begin
          alu_we     = 1'b1;
          alu_in     = is_lui ? imm : alu_res;
          next_state = S_WB;
        end else if (is_lw || is_sw) begin
          alu_we     = 1'b1;
          alu_in     = ls_addr;
          next_state = (ls_addr[1:0] == 2'b00) ? S_MEM : S_HALT;
        end else if (is_br) begin
          if (br_taken && br_target[1]) begin
            next_state = S_HALT;
          end else begin
            pc_we      = 1'b1;
            pc_next    = br_taken ? br_target : (pc + 32'd4);
            ret_c      = 1'b1;
            next_state = S_FETCH;
          end
        end else begin
          // jal / jalr: a target with bit 1 set halts without writing rd.
          if (jmp_target[1]) begin
            next_state = S_HALT;
          end else begin
            rf_we      = 1'b1;
            rf_wdata   = pc + 32'd4;
            pc_we      = 1'b1;
            pc_next    = jmp_target;
            ret_c      = 1'b1;
            next_state = S_FETCH;
          end
        end
      end
      S_MEM: begin
        req_c   = 1'b1;
        we_c    = is_sw;
        addr_c  = alu_out;
        wdata_c = b_reg;
        if (mem_ready) begin
          if (is_sw) begin
            pc_we      = 1'b1;
            ret_c      = 1'b1;
            next_state = S_FETCH;
          end else begin
            mdr_we     = 1'b1;
            next_state = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        rf_wdata   = is_lw ? mdr : alu_out;
        pc_we      = 1'b1;
        ret_c      = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_HALT;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_VECTOR;
      ir      <= 32'h0;
      a_reg   <= 32'h0;
      b_reg   <= 32'h0;
      alu_out <= 32'h0;
      mdr     <= 32'h0;
    end else begin
      if (ir_we)  ir      <= mem_rdata;
      if (ab_we) begin
        a_reg <= rf[rs1_f[RAW-1:0]];
        b_reg <= rf[rs2_f[RAW-1:0]];
      end
      if (alu_we) alu_out <= alu_in;
      if (mdr_we) mdr     <= mem_rdata;
      if (pc_we)  pc      <= pc_next;
    end
  end

  // Register file; entry 0 is never written so x0 always reads 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= 32'h0;
    end else if (rf_we && rd_f != 5'd0) begin
      rf[rd_f[RAW-1:0]] <= rf_wdata;
    end
  end

  // Outputs; reset and HALT keep the port quiescent
  always_comb begin
    mem_req   = req_c & ~rst;
    mem_we    = we_c & ~rst;
    mem_addr  = addr_c[ADDR_WIDTH-1:0];
    mem_wdata = wdata_c;
    retire    = ret_c & ~rst;
    halted    = (state == S_HALT) & ~rst;
    a0        = rf[10];
  end

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed programs against a word memory model with a
// programmable number of wait states per access. Every cycle after reset is
// recorded (cycle 1 = first cycle after the reset edge) and checked against
// hand-computed cycle positions and values.
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, a0;

  int checks = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  multicycle_core #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .a0        (a0),
    .retire    (retire),
    .halted    (halted)
  );

  // Memory model: 64 words, wait_n wait states before mem_ready
  logic [31:0] mem [64];
  int          wait_n = 0;
  int          wcnt = 0;
  logic        ld_we = 1'b0;
  logic [5:0]  ld_idx = 6'd0;
  logic [31:0] ld_data = 32'h0;

  assign mem_ready = mem_req && (wcnt == wait_n);
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (ld_we) mem[ld_idx] <= ld_data;
    else if (mem_req && mem_ready && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    if (rst || !mem_req || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Per-cycle record and fetch-address scoreboard
  logic        rec_req [128];
  logic        rec_we [128];
  logic        rec_ret [128];
  logic        rec_halt [128];
  logic [31:0] rec_addr [128];
  logic [31:0] rec_wdata [128];
  logic [31:0] rec_a0 [128];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (cyc < 128) begin
      rec_req[cyc]   = mem_req;
      rec_we[cyc]    = mem_we;
      rec_ret[cyc]   = retire;
      rec_halt[cyc]  = halted;
      rec_addr[cyc]  = mem_addr;
      rec_wdata[cyc] = mem_wdata;
      rec_a0[cyc]    = a0;
    end
    if (mem_req && mem_ready && !mem_we) got_q.push_back(mem_addr);
  endtask

  task automatic begin_reset(input int w);
    @(negedge clk);
    rst    = 1'b1;
    wait_n = w;
    got_q.delete();
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    ld_idx  = idx[5:0];
    ld_data = d;
    ld_we   = 1'b1;
    @(negedge clk);
    ld_we   = 1'b0;
  endtask

  task automatic check_in_reset(input string tag);
    #1;
    chk({tag, "_rst_req"}, {31'b0, mem_req}, 32'd0);
    chk({tag, "_rst_halted"}, {31'b0, halted}, 32'd0);
    chk({tag, "_rst_retire"}, {31'b0, retire}, 32'd0);
  endtask

  task automatic run(input int n);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cyc = 1;
    sample();
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      #1;
      cyc++;
      sample();
    end
  endtask

  int nret;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // P1: addi x10,x0,5; addi x10,x10,-7; illegal word -> HALT
    begin_reset(0);
    load(0, 32'h0050_0513);
    load(1, 32'hFF95_0513);
    load(2, 32'h0000_0000);
    check_in_reset("p1");
    run(14);
    chk("p1_c1_req",   {31'b0, rec_req[1]}, 32'd1);
    chk("p1_c1_we",    {31'b0, rec_we[1]}, 32'd0);
    chk("p1_c1_addr",  rec_addr[1], 32'h0);
    chk("p1_c1_wdata", rec_wdata[1], 32'h0);
    chk("p1_c1_a0",    rec_a0[1], 32'h0);
    chk("p1_ret3",     {31'b0, rec_ret[3]}, 32'd0);
    chk("p1_ret4",     {31'b0, rec_ret[4]}, 32'd1);
    chk("p1_ret7",     {31'b0, rec_ret[7]}, 32'd0);
    chk("p1_ret8",     {31'b0, rec_ret[8]}, 32'd1);
    chk("p1_a0_c9",    rec_a0[9], 32'hFFFF_FFFE);
    chk("p1_halt10",   {31'b0, rec_halt[10]}, 32'd0);
    chk("p1_halt11",   {31'b0, rec_halt[11]}, 32'd1);
    for (int c = 11; c <= 14; c++) chk($sformatf("p1_req_c%0d", c), {31'b0, rec_req[c]}, 32'd0);

    // P2: 3 wait states; addi x10,0x123; sw x10,0x80(x0); lw x11,0x80(x0);
    // add x10,x11,x0. With the wait states on both the fetch and the data
    // access, sw occupies cycles 8..17 and lw 18..28.
    begin_reset(3);
    load(0, 32'h1230_0513);
    load(1, 32'h08A0_2023);
    load(2, 32'h0800_2583);
    load(3, 32'h0005_8533);
    load(4, 32'h0000_0000);
    load(32, 32'hDEAD_BEEF);
    check_in_reset("p2");
    run(42);
    chk("p2_c1_a0",   rec_a0[1], 32'h0);
    chk("p2_c1_addr", rec_addr[1], 32'h0);
    chk("p2_c1_req",  {31'b0, rec_req[1]}, 32'd1);
    nret = 0;
    for (int c = 1; c <= 35; c++) if (rec_ret[c]) nret++;
    chk("p2_nret", nret, 32'd4);
    chk("p2_ret7",  {31'b0, rec_ret[7]}, 32'd1);
    chk("p2_ret17", {31'b0, rec_ret[17]}, 32'd1);
    chk("p2_ret28", {31'b0, rec_ret[28]}, 32'd1);
    chk("p2_ret35", {31'b0, rec_ret[35]}, 32'd1);
    for (int c = 8; c <= 11; c++) begin
      chk($sformatf("p2_fetch_addr_c%0d", c), rec_addr[c], 32'h4);
      chk($sformatf("p2_fetch_req_c%0d", c), {31'b0, rec_req[c]}, 32'd1);
    end
    chk("p2_we_c13", {31'b0, rec_we[13]}, 32'd0);
    for (int c = 14; c <= 17; c++) begin
      chk($sformatf("p2_st_we_c%0d", c), {31'b0, rec_we[c]}, 32'd1);
      chk($sformatf("p2_st_addr_c%0d", c), rec_addr[c], 32'h80);
      chk($sformatf("p2_st_wdata_c%0d", c), rec_wdata[c], 32'h123);
    end
    chk("p2_mem32", mem[32], 32'h123);
    for (int c = 24; c <= 27; c++) chk($sformatf("p2_ld_addr_c%0d", c), rec_addr[c], 32'h80);
    chk("p2_a0_c36", rec_a0[36], 32'h123);
    chk("p2_halt41", {31'b0, rec_halt[41]}, 32'd1);

    // P3: bne loop counting x10 3->0, then taken beq over 0x10 to 0x14
    begin_reset(0);
    load(0, 32'h0030_0513);
    load(1, 32'hFFF5_0513);
    load(2, 32'hFE05_1EE3);
    load(3, 32'h0000_0463);
    load(4, 32'h0550_0513);
    load(5, 32'h0000_0000);
    run(33);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'h4, 32'h8, 32'h4, 32'h8, 32'hC, 32'h14};
    chk("p3_nfetch", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk($sformatf("p3_pc_%0d", k), got_q[k], exp_q[k]);
    chk("p3_ret8",  {31'b0, rec_ret[8]}, 32'd1);
    chk("p3_ret9",  {31'b0, rec_ret[9]}, 32'd0);
    chk("p3_ret10", {31'b0, rec_ret[10]}, 32'd0);
    chk("p3_ret11", {31'b0, rec_ret[11]}, 32'd1);
    chk("p3_halt31", {31'b0, rec_halt[31]}, 32'd1);
    chk("p3_a0_c32", rec_a0[32], 32'h0);

    // P4: nops, jal x1,+8 at 0x10, add x10,x1,x0, addi x5,x0,0x20,
    // jalr x10,2(x5) -> target 0x22 halts without writing x10
    begin_reset(0);
    load(0, 32'h0000_0013);
    load(1, 32'h0000_0013);
    load(2, 32'h0000_0013);
    load(3, 32'h0000_0013);
    load(4, 32'h0080_00EF);
    load(5, 32'h0000_0000);
    load(6, 32'h0000_8533);
    load(7, 32'h0200_0293);
    load(8, 32'h0022_8567);
    run(34);
    chk("p4_ret19",    {31'b0, rec_ret[19]}, 32'd1);
    chk("p4_fetch_c20", rec_addr[20], 32'h18);
    chk("p4_a0_c24",   rec_a0[24], 32'h14);
    chk("p4_ret30",    {31'b0, rec_ret[30]}, 32'd0);
    chk("p4_halt30",   {31'b0, rec_halt[30]}, 32'd0);
    chk("p4_halt31",   {31'b0, rec_halt[31]}, 32'd1);
    for (int c = 31; c <= 34; c++) chk($sformatf("p4_req_c%0d", c), {31'b0, rec_req[c]}, 32'd0);
    chk("p4_a0_c34",   rec_a0[34], 32'h14);

    // P5: addi x16,x0,1; add x10,x16,x0
    begin_reset(0);
    load(0, 32'h0010_0813);
    load(1, 32'h0008_0533);
    load(2, 32'h0000_0000);
`ifdef RV32E_EN
    run(5);
    chk("p5_halt3", {31'b0, rec_halt[3]}, 32'd1);
    chk("p5_a0_c5", rec_a0[5], 32'h0);
`else
    run(9);
    chk("p5_ret4",  {31'b0, rec_ret[4]}, 32'd1);
    chk("p5_ret8",  {31'b0, rec_ret[8]}, 32'd1);
    chk("p5_a0_c9", rec_a0[9], 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
